// File: rtl/img_server.sv
// Template (f) / search (g) image store: raster-order load, then 1-cycle registered pixel reads.
// Load backpressure: load_ready only while loading; reads never stall, one rvalid per req in order.
module img_server #(
    parameter int FW   = 16,
    parameter int GW   = 94,
    parameter int ROWS = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_load,
    input  logic       load_valid,
    input  logic [2:0] load_data,
    output logic       load_ready,
    output logic       ready,
    input  logic       req,
    input  logic [6:0] vector_xf,
    input  logic [6:0] vector_xg,
    input  logic [3:0] vector_y,
    output logic [2:0] getfdata,
    output logic [2:0] gdata,
    output logic [5:0] get2f,
    output logic       rvalid,
    output logic       err
);

    localparam int FA_W = $clog2(FW * ROWS);
    localparam int GA_W = $clog2(GW * ROWS);

    localparam logic [1:0] S_EMPTY  = 2'd0;
    localparam logic [1:0] S_LOAD_F = 2'd1;
    localparam logic [1:0] S_LOAD_G = 2'd2;
    localparam logic [1:0] S_READY  = 2'd3;

    logic [1:0] state_q, state_d;
    logic [6:0] col_q, col_d;
    logic [3:0] row_q, row_d;
    logic       err_q, err_d;
    logic       rvalid_q, rvalid_d;
    logic [2:0] getf_q, getf_d;
    logic [2:0] gdat_q, gdat_d;
    logic [5:0] get2f_q, get2f_d;

    logic [2:0] f_mem [FW*ROWS];
    logic [2:0] g_mem [GW*ROWS];

    logic            beat;
    logic            last_col;
    logic            f_we, g_we;
    logic [FA_W-1:0] f_waddr, f_raddr;
    logic [GA_W-1:0] g_waddr, g_raddr;
    logic            rd_ok;
    logic [2:0]      f_rd, g_rd;
    logic [5:0]      f_sq;

    assign load_ready = (state_q == S_LOAD_F) || (state_q == S_LOAD_G);
    assign ready      = (state_q == S_READY);

    // A restart pulse wins over any beat presented in the same cycle.
    assign beat = load_valid && load_ready && !start_load;

    assign f_waddr = FA_W'(int'(row_q) * FW + int'(col_q));
    assign g_waddr = GA_W'(int'(row_q) * GW + int'(col_q));

    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        row_d    = row_q;
        f_we     = 1'b0;
        g_we     = 1'b0;
        last_col = 1'b0;
        if (start_load) begin
            state_d = S_LOAD_F;
            col_d   = '0;
            row_d   = '0;
        end else if (beat) begin
            f_we     = (state_q == S_LOAD_F);
            g_we     = (state_q == S_LOAD_G);
            last_col = (state_q == S_LOAD_F) ? (col_q == 7'(FW - 1))
                                             : (col_q == 7'(GW - 1));
            if (last_col) begin
                col_d = '0;
                row_d = row_q + 4'd1;
                if (row_q == 4'(ROWS - 1)) begin
                    row_d   = '0;
                    state_d = (state_q == S_LOAD_F) ? S_LOAD_G : S_READY;
                end
            end else begin
                col_d = col_q + 7'd1;
            end
        end
    end

    // Image storage carries no reset; contents are meaningless until a full load.
    always_ff @(posedge clk) begin
        if (f_we) begin
            f_mem[f_waddr] <= load_data;
        end
        if (g_we) begin
            g_mem[g_waddr] <= load_data;
        end
    end

    assign rd_ok = (state_q == S_READY) && !start_load
                && (vector_xf <= 7'(FW - 1)) && (vector_xg <= 7'(GW - 1));

    assign f_raddr = FA_W'(int'(vector_y) * FW + int'(vector_xf));
    assign g_raddr = GA_W'(int'(vector_y) * GW + int'(vector_xg));
    assign f_rd    = f_mem[f_raddr];
    assign g_rd    = g_mem[g_raddr];
    assign f_sq    = {3'b000, f_rd} * {3'b000, f_rd};

    always_comb begin
        rvalid_d = req;
        getf_d   = getf_q;
        gdat_d   = gdat_q;
        get2f_d  = get2f_q;
        err_d    = err_q;
        if (req) begin
            if (rd_ok) begin
                getf_d  = f_rd;
                gdat_d  = g_rd;
                get2f_d = f_sq;
            end else begin
                getf_d  = '0;
                gdat_d  = '0;
                get2f_d = '0;
            end
        end
        // A bad read in the restart cycle must still leave err set.
        if (req && !rd_ok) begin
            err_d = 1'b1;
        end else if (start_load) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_EMPTY;
            col_q    <= '0;
            row_q    <= '0;
            err_q    <= 1'b0;
            rvalid_q <= 1'b0;
            getf_q   <= '0;
            gdat_q   <= '0;
            get2f_q  <= '0;
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            row_q    <= row_d;
            err_q    <= err_d;
            rvalid_q <= rvalid_d;
            getf_q   <= getf_d;
            gdat_q   <= gdat_d;
            get2f_q  <= get2f_d;
        end
    end

    assign getfdata = getf_q;
    assign gdata    = gdat_q;
    assign get2f    = get2f_q;
    assign rvalid   = rvalid_q;
    assign err      = err_q;

endmodule
